// File: rtl/coin_spawner.sv
// Frame-paced coin scheduler: launches one coin at a time into a pseudo-random lane,
// opens a collection window on in_position, and keeps the score and miss counters.
module coin_spawner #(
  parameter int unsigned SPAWN_GAP_FRAMES = 45,
  parameter int unsigned WINDOW_FRAMES    = 20,
  parameter int unsigned TRAVEL_TIMEOUT   = 64,
  parameter logic [7:0]  LFSR_SEED        = 8'hA5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_v_sync,
  input  logic        i_enable,
  input  logic [1:0]  i_player_lane,
  input  logic [2:0]  i_in_position,
  output logic [2:0]  o_active,
  output logic [1:0]  o_lane,
  output logic [15:0] o_score,
  output logic [7:0]  o_miss_count,
  output logic        o_collect_pulse,
  output logic        o_miss_pulse
);

  localparam int unsigned GAP_W  = (SPAWN_GAP_FRAMES > 1) ? $clog2(SPAWN_GAP_FRAMES) : 1;
  localparam int unsigned TRAV_W = (TRAVEL_TIMEOUT > 1) ? $clog2(TRAVEL_TIMEOUT) : 1;
  localparam int unsigned WIN_W  = (WINDOW_FRAMES > 1) ? $clog2(WINDOW_FRAMES) : 1;

  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(SPAWN_GAP_FRAMES - 1);
  localparam logic [TRAV_W-1:0] TRAV_LOAD = TRAV_W'(TRAVEL_TIMEOUT - 1);
  localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(WINDOW_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_LIVE,
    S_WINDOW
  } state_t;

  state_t state_q, state_d;

  logic vs_meta_q, vs_sync_q, vs_prev_q, tick_q;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [TRAV_W-1:0] trav_q, trav_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        active_q, active_d;
  logic [15:0]       score_q, score_d;
  logic [7:0]        miss_q, miss_d;
  logic              cpulse_q, cpulse_d;
  logic              mpulse_q, mpulse_d;

  logic [1:0] lane_cand;
  logic       do_collect, do_miss;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
      vs_prev_q <= 1'b0;
      tick_q    <= 1'b0;
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      gap_q     <= '0;
      trav_q    <= '0;
      win_q     <= '0;
      lane_q    <= 2'd0;
      active_q  <= 3'b000;
      score_q   <= 16'd0;
      miss_q    <= 8'd0;
      cpulse_q  <= 1'b0;
      mpulse_q  <= 1'b0;
    end else begin
      vs_meta_q <= i_v_sync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
      tick_q    <= vs_sync_q & ~vs_prev_q;
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      gap_q     <= gap_d;
      trav_q    <= trav_d;
      win_q     <= win_d;
      lane_q    <= lane_d;
      active_q  <= active_d;
      score_q   <= score_d;
      miss_q    <= miss_d;
      cpulse_q  <= cpulse_d;
      mpulse_q  <= mpulse_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    trav_d     = trav_q;
    win_d      = win_q;
    lane_d     = lane_q;
    active_d   = active_q;
    score_d    = score_q;
    miss_d     = miss_q;
    cpulse_d   = 1'b0;
    mpulse_d   = 1'b0;
    do_collect = 1'b0;
    do_miss    = 1'b0;

    // The lane candidate is taken from the value after this tick's shift.
    lfsr_d    = tick_q ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
    lane_cand = (lfsr_d[1:0] == 2'd3) ? 2'd1 : lfsr_d[1:0];

    if (!i_enable) begin
      state_d  = S_IDLE;
      active_d = 3'b000;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d  = S_GAP;
          gap_d    = GAP_LOAD;
          active_d = 3'b000;
        end
        S_GAP: begin
          if (tick_q) begin
            if (gap_q == '0) begin
              lane_d   = lane_cand;
              active_d = 3'(3'b001 << lane_cand);
              trav_d   = TRAV_LOAD;
              state_d  = S_LIVE;
            end else begin
              gap_d = gap_q - GAP_W'(1);
            end
          end
        end
        S_LIVE: begin
          if (tick_q) begin
            if (i_in_position[lane_q]) begin
              win_d   = WIN_LOAD;
              state_d = S_WINDOW;
            end else if (trav_q == '0) begin
              do_miss = 1'b1;
            end else begin
              trav_d = trav_q - TRAV_W'(1);
            end
          end
        end
        S_WINDOW: begin
          if (tick_q) begin
            if (i_player_lane == lane_q) begin
              do_collect = 1'b1;
            end else if (win_q == '0) begin
              do_miss = 1'b1;
            end else begin
              win_d = win_q - WIN_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (do_collect) begin
      score_d  = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
      cpulse_d = 1'b1;
    end
    if (do_miss) begin
      miss_d   = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
      mpulse_d = 1'b1;
    end
    if (do_collect || do_miss) begin
      active_d = 3'b000;
      gap_d    = GAP_LOAD;
      state_d  = S_GAP;
    end
  end

  assign o_active        = active_q;
  assign o_lane          = lane_q;
  assign o_score         = score_q;
  assign o_miss_count    = miss_q;
  assign o_collect_pulse = cpulse_q;
  assign o_miss_pulse    = mpulse_q;

endmodule

// File: doc/coin_spawner.md
# coin_spawner

Frame-paced coin scheduler that sits directly upstream of the per-lane coin sprite stages (left/mid/right). It decides when and in which lane a coin is launched by driving each coin stage's `active` input. It consumes each coin's `in_position` flag to open a collection window, and resolves the coin as collected or missed from the player's lane. It also owns the running score and miss counters fed to the HUD.

## Interface
Parameters:
- `SPAWN_GAP_FRAMES`, default 45: frames with all coins inactive between consecutive coins; must be ≥1.
- `WINDOW_FRAMES`, default 20: frames a coin stays collectable after `in_position` is seen.
- `TRAVEL_TIMEOUT`, default 64: maximum frames from launch to `in_position` before a forced miss.
- `LFSR_SEED`, default 8'hA5: lane LFSR reset value; must be nonzero.

Ports (all synchronous to `i_clk`):
- `i_clk` in 1: system pixel clock.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_v_sync` in 1: raw vertical sync, asynchronous to the block's logic; rising edge marks a frame.
- `i_enable` in 1: game running; low forces IDLE.
- `i_player_lane` in 2: 0 left, 1 mid, 2 right; 3 never matches any lane.
- `i_in_position` in 3: per-lane `in_position` from the coin stages; bit0 left, bit1 mid, bit2 right.
- `o_active` out 3: per-lane `active` to the coin stages; at most one bit is high.
- `o_lane` out 2: lane of the current or most recent coin.
- `o_score` out 16: collected count, saturates at 16'hFFFF.
- `o_miss_count` out 8: missed count, saturates at 8'hFF.
- `o_collect_pulse` out 1: one-cycle strobe on collect.
- `o_miss_pulse` out 1: one-cycle strobe on miss.

## Operation
- Frame tick: `i_v_sync` passes through a 2-flop synchroniser, then rising-edge detect. `tick` is high for exactly one `i_clk` cycle per frame.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Shifts on every `tick`, in all states.
  - Lane candidate = `lfsr[1:0]`; the value 3 maps to 1 (mid).
- States: IDLE, GAP, LIVE, WINDOW.
- IDLE: `o_active`=0. When `i_enable`=1, go to GAP and load `gap_cnt`=`SPAWN_GAP_FRAMES`-1.
- GAP: `o_active`=0.
  - On `tick`, if `gap_cnt`==0: latch the lane candidate into `o_lane`, set `o_active[o_lane]`=1, load `trav_cnt`=`TRAVEL_TIMEOUT`-1, go to LIVE.
  - Otherwise, on `tick`, decrement `gap_cnt`.
- LIVE: on `tick`:
  - If `i_in_position[o_lane]`=1: load `win_cnt`=`WINDOW_FRAMES`-1 and go to WINDOW.
  - Else if `trav_cnt`==0: resolve as a miss.
  - Else decrement `trav_cnt`.
  - Only the latched lane's `i_in_position` bit is examined.
- WINDOW: on `tick`:
  - If `i_player_lane`==`o_lane`: collect.
  - Else if `win_cnt`==0: miss.
  - Else decrement `win_cnt`.
  - Collect is checked before expiry on the same tick, so a match on the last window frame counts as a collect.
- Collect: `o_score`+1 (saturating), `o_collect_pulse`=1 for one cycle, `o_active`=0, reload `gap_cnt`, go to GAP.
- Miss: `o_miss_count`+1 (saturating), `o_miss_pulse`=1 for one cycle, `o_active`=0, reload `gap_cnt`, go to GAP.
- `i_enable`=0 in any state: next cycle go to IDLE with `o_active`=0, no pulse, counters held, LFSR keeps shifting.
  - Enable takes priority over a simultaneous `tick`.
- `SPAWN_GAP_FRAMES`≥1 guarantees `o_active` is low across at least one `i_v_sync` edge, so each coin stage returns to its start position before relaunch.

## Timing
- Reset values (cycle after `i_rst_n` is sampled low):
  - state IDLE, `o_active`=0, `o_lane`=0.
  - `o_score`=0, `o_miss_count`=0, both pulses 0.
  - `lfsr`=`LFSR_SEED`, synchroniser flops 0.
- `tick` asserts 3 `i_clk` cycles after the `i_v_sync` rising edge: 2 sync stages plus 1 edge register.
- All outputs are registered and update on the cycle after `tick` (or after `i_enable` falls).
- A coin stage, clocked by `i_v_sync`, first sees `o_active` high on the v_sync edge following the launch tick.
- Frame count from entering GAP to launch is exactly `SPAWN_GAP_FRAMES` ticks.
- Reset mid-operation: `o_active` drops on the next cycle and all counts clear; a pending pulse is suppressed.
- `i_in_position` and `i_player_lane` are sampled only on `tick` cycles; values between ticks are ignored.

## Test plan
- Reset, then enable with `SPAWN_GAP_FRAMES`=3 and seed 8'hA5 → `o_active` stays 0 for 2 ticks; on the 3rd tick exactly one bit rises, and its lane equals the value derived from the LFSR after 3 shifts.
- Launch into lane 1, raise `i_in_position[1]` on tick 5, hold `i_player_lane`=1 → collect on tick 6: `o_score`=1, one-cycle `o_collect_pulse`, `o_active`=0.
- `WINDOW_FRAMES`=4, `i_player_lane`=0 while the coin is in lane 2 → miss on the 4th window tick: `o_miss_count`=1, one `o_miss_pulse`. Repeating with the player moving to lane 2 exactly on the 4th tick → collect instead.
- `TRAVEL_TIMEOUT`=8, never raise `i_in_position`; raise the wrong lane's bit on every tick → forced miss after 8 LIVE ticks.
- Drop `i_enable` in WINDOW on the same cycle as `tick` with a matching lane → no collect and no pulse, `o_active`=0, score unchanged. Re-enable → GAP restarts from full count.
- Preload `o_score` to 16'hFFFF by forcing, then collect → `o_score` stays 16'hFFFF and the pulse still fires. Separately, assert `i_rst_n`=0 mid-LIVE → all outputs at reset values next cycle.
